tl_ad_buffer: RTL and testbench

- Registered two-channel TileLink-UL buffer stage (A and D channels) placed directly downstream of the single-port system crossbar, between its `auto_out` node and the peripheral fabric.
- Breaks the combinational ready/valid/data paths the crossbar passes straight through, using one independent FIFO per channel.
- Payload fields are carried unchanged. Ordering within each channel is preserved.

---
 rtl/tl_ad_pkg.sv | 38 +++
 rtl/tl_ad_fifo.sv | 88 ++++++++
 rtl/tl_ad_buffer.sv | 110 +++++++++++
 tb/tb_tl_ad_buffer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_ad_pkg.sv
// Shared TileLink-UL field widths and beat bundles
// for the A/D channel buffer stage.
package tl_ad_pkg;

  localparam int OPC_W  = 3;
  localparam int PARM_W = 2;
  localparam int SIZE_W = 4;
  localparam int ADDR_W = 32;
  localparam int MASK_W = 8;
  localparam int DATA_W = 64;
  localparam int SINK_W = 3;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [SIZE_W-1:0] size;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } tl_a_beat_t;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [PARM_W-1:0] param;
    logic [SIZE_W-1:0] size;
    logic [SINK_W-1:0] sink;
    logic              denied;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } tl_d_beat_t;

  localparam int A_BEAT_W = $bits(tl_a_beat_t);
  localparam int D_BEAT_W = $bits(tl_d_beat_t);

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tl_ad_fifo.sv
// Registered valid/ready FIFO, DEPTH 1..8, any width.
// Optional flow-through: TL_AD_BUFFER_FLOW_EN.
module tl_ad_fifo
  import tl_ad_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [W-1:0]  last_q;
  logic          empty;
  logic          flow;
  logic          deq;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] adv(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (count == '0);
  // ready looks only at local occupancy
  assign in_ready = rst_n && (count != FULL);

`ifdef TL_AD_BUFFER_FLOW_EN
  assign flow = rst_n && empty && in_valid;
`else
  assign flow = 1'b0;
`endif

  assign out_valid = !empty || flow;
  // empty: show the last beat handed out
  assign out_data  = !empty ? mem[rd_ptr] :
                     flow   ? in_data     :
                              last_q;

  assign deq  = out_valid && out_ready;
  assign pop  = deq && !empty;
  // a flowed beat taken this cycle is never stored
  assign push = in_valid && in_ready &&
                !(flow && out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      last_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= adv(wr_ptr);
      end
      if (pop)
        rd_ptr <= adv(rd_ptr);
      if (deq)
        last_q <= out_data;
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tl_ad_buffer.sv
// TileLink-UL A/D buffer stage behind the crossbar.
// Ports: auto_in_* (crossbar), auto_out_* (fabric).
module tl_ad_buffer
  import tl_ad_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [3:0]  auto_in_a_bits_size,
  input  logic [31:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [1:0]  auto_in_d_bits_param,
  output logic [3:0]  auto_in_d_bits_size,
  output logic [2:0]  auto_in_d_bits_sink,
  output logic        auto_in_d_bits_denied,
  output logic [63:0] auto_in_d_bits_data,
  output logic        auto_in_d_bits_corrupt,
  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [3:0]  auto_out_a_bits_size,
  output logic [31:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [1:0]  auto_out_d_bits_param,
  input  logic [3:0]  auto_out_d_bits_size,
  input  logic [2:0]  auto_out_d_bits_sink,
  input  logic        auto_out_d_bits_denied,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_out_d_bits_corrupt
);

  tl_a_beat_t a_in;
  tl_a_beat_t a_out;
  tl_d_beat_t d_in;
  tl_d_beat_t d_out;

  assign a_in = {
    auto_in_a_bits_opcode,
    auto_in_a_bits_size,
    auto_in_a_bits_address,
    auto_in_a_bits_mask,
    auto_in_a_bits_data
  };

  assign d_in = {
    auto_out_d_bits_opcode,
    auto_out_d_bits_param,
    auto_out_d_bits_size,
    auto_out_d_bits_sink,
    auto_out_d_bits_denied,
    auto_out_d_bits_data,
    auto_out_d_bits_corrupt
  };

  tl_ad_fifo #(
    .DEPTH (A_DEPTH),
    .W     (A_BEAT_W)
  ) u_a_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .in_valid  (auto_in_a_valid),
    .in_ready  (auto_in_a_ready),
    .in_data   (a_in),
    .out_valid (auto_out_a_valid),
    .out_ready (auto_out_a_ready),
    .out_data  (a_out)
  );

  tl_ad_fifo #(
    .DEPTH (D_DEPTH),
    .W     (D_BEAT_W)
  ) u_d_fifo (
    .clk       (clock),
    .rst_n     (reset),
    .in_valid  (auto_out_d_valid),
    .in_ready  (auto_out_d_ready),
    .in_data   (d_in),
    .out_valid (auto_in_d_valid),
    .out_ready (auto_in_d_ready),
    .out_data  (d_out)
  );

  assign auto_out_a_bits_opcode  = a_out.opcode;
  assign auto_out_a_bits_size    = a_out.size;
  assign auto_out_a_bits_address = a_out.address;
  assign auto_out_a_bits_mask    = a_out.mask;
  assign auto_out_a_bits_data    = a_out.data;

  assign auto_in_d_bits_opcode  = d_out.opcode;
  assign auto_in_d_bits_param   = d_out.param;
  assign auto_in_d_bits_size    = d_out.size;
  assign auto_in_d_bits_sink    = d_out.sink;
  assign auto_in_d_bits_denied  = d_out.denied;
  assign auto_in_d_bits_data    = d_out.data;
  assign auto_in_d_bits_corrupt = d_out.corrupt;

endmodule

// File: tb/tb_tl_ad_buffer.sv
// Bench for tl_ad_buffer: vector table, scoreboard
// queues per channel and reset/stream sequences.
module tb_tl_ad_buffer;
  import tl_ad_pkg::*;

`ifdef TL_AD_BUFFER_FLOW_EN
  localparam bit FLOW = 1'b1;
`else
  localparam bit FLOW = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_iv = 1'b0;
  logic       a_ir;
  logic       a_or = 1'b0;
  logic       a_ov;
  logic       d_iv = 1'b0;
  logic       d_ir;
  logic       d_or = 1'b0;
  logic       d_ov;
  tl_a_beat_t ain = '0;
  tl_d_beat_t din = '0;
  tl_a_beat_t aout;
  tl_d_beat_t dout;

  logic [2:0]  ao_opc;
  logic [3:0]  ao_size;
  logic [31:0] ao_addr;
  logic [7:0]  ao_mask;
  logic [63:0] ao_data;
  logic [2:0]  do_opc;
  logic [1:0]  do_parm;
  logic [3:0]  do_size;
  logic [2:0]  do_sink;
  logic        do_den;
  logic [63:0] do_data;
  logic        do_cor;

  assign aout = {ao_opc, ao_size, ao_addr,
                 ao_mask, ao_data};
  assign dout = {do_opc, do_parm, do_size,
                 do_sink, do_den, do_data, do_cor};

  tl_ad_buffer #(
    .A_DEPTH (2),
    .D_DEPTH (2)
  ) dut (
    .clock                   (clk),
    .reset                   (rst_n),
    .auto_in_a_ready         (a_ir),
    .auto_in_a_valid         (a_iv),
    .auto_in_a_bits_opcode   (ain.opcode),
    .auto_in_a_bits_size     (ain.size),
    .auto_in_a_bits_address  (ain.address),
    .auto_in_a_bits_mask     (ain.mask),
    .auto_in_a_bits_data     (ain.data),
    .auto_in_d_ready         (d_or),
    .auto_in_d_valid         (d_ov),
    .auto_in_d_bits_opcode   (do_opc),
    .auto_in_d_bits_param    (do_parm),
    .auto_in_d_bits_size     (do_size),
    .auto_in_d_bits_sink     (do_sink),
    .auto_in_d_bits_denied   (do_den),
    .auto_in_d_bits_data     (do_data),
    .auto_in_d_bits_corrupt  (do_cor),
    .auto_out_a_ready        (a_or),
    .auto_out_a_valid        (a_ov),
    .auto_out_a_bits_opcode  (ao_opc),
    .auto_out_a_bits_size    (ao_size),
    .auto_out_a_bits_address (ao_addr),
    .auto_out_a_bits_mask    (ao_mask),
    .auto_out_a_bits_data    (ao_data),
    .auto_out_d_ready        (d_ir),
    .auto_out_d_valid        (d_iv),
    .auto_out_d_bits_opcode  (din.opcode),
    .auto_out_d_bits_param   (din.param),
    .auto_out_d_bits_size    (din.size),
    .auto_out_d_bits_sink    (din.sink),
    .auto_out_d_bits_denied  (din.denied),
    .auto_out_d_bits_data    (din.data),
    .auto_out_d_bits_corrupt (din.corrupt)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int a_outs = 0;
  int d_outs = 0;
  int a_first = -1;
  int a_last = -1;
  int d_first = -1;
  int d_last = -1;
  tl_a_beat_t qa[$];
  tl_d_beat_t qd[$];

  task automatic check(input string nm,
                       input logic [127:0] act,
                       input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  function automatic tl_a_beat_t mk_a(input int k);
    tl_a_beat_t b;
    b.opcode  = 3'(k);
    b.size    = 4'(k + 1);
    b.address = 32'h1000_0000 + 32'(k * 16);
    b.mask    = 8'(k * 3 + 1);
    b.data    = {32'(k), 32'hA5A5_0000 + 32'(k)};
    return b;
  endfunction

  function automatic tl_d_beat_t mk_d(input int k);
    tl_d_beat_t b;
    b.opcode  = 3'(k + 1);
    b.param   = 2'(k);
    b.size    = 4'(k);
    b.sink    = 3'(k + 2);
    b.denied  = k[0];
    b.data    = {32'hD00D_0000 + 32'(k), 32'(~k)};
    b.corrupt = k[1];
    return b;
  endfunction

  // scoreboard: push on enqueue, pop on dequeue
  task automatic mon();
    tl_a_beat_t ea;
    tl_d_beat_t ed;
    if (a_iv && a_ir)
      qa.push_back(ain);
    if (d_iv && d_ir)
      qd.push_back(din);
    if (a_ov && a_or) begin
      a_outs++;
      if (a_first < 0) a_first = cyc;
      a_last = cyc;
      if (qa.size() == 0) begin
        check("a_extra_beat", 1, 0);
      end else begin
        ea = qa.pop_front();
        check("a_beat", aout, ea);
      end
    end
    if (d_ov && d_or) begin
      d_outs++;
      if (d_first < 0) d_first = cyc;
      d_last = cyc;
      if (qd.size() == 0) begin
        check("d_extra_beat", 1, 0);
      end else begin
        ed = qd.pop_front();
        check("d_beat", dout, ed);
      end
    end
  endtask

  task automatic fin();
    mon();
    @(negedge clk);
    cyc++;
  endtask

  task automatic idle();
    a_iv = 0; a_or = 0; d_iv = 0; d_or = 0;
    ain = '0; din = '0;
  endtask

  typedef struct {
    bit av; bit ar_o; int ab;
    bit dv; bit dr_o; int db;
    bit e_ar; bit e_av; bit e_avf;
    bit e_dr; bit e_dv; bit e_dvf;
  } vec_t;

  vec_t vt[8];

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    tl_a_beat_t sb;
    tl_d_beat_t rd;
    int n;

    vt[0] = '{0,0,0, 0,1,0, 1,0,0, 1,0,0};
    vt[1] = '{1,0,1, 1,1,1, 1,0,1, 1,0,1};
    vt[2] = '{1,0,2, 0,1,0, 1,1,1, 1,1,0};
    vt[3] = '{1,0,3, 0,1,0, 0,1,1, 1,0,0};
    vt[4] = '{1,1,3, 0,1,0, 0,1,1, 1,0,0};
    vt[5] = '{1,1,3, 0,1,0, 1,1,1, 1,0,0};
    vt[6] = '{0,1,0, 0,1,0, 1,1,1, 1,0,0};
    vt[7] = '{0,1,0, 0,1,0, 1,0,0, 1,0,0};

    idle();
    @(negedge clk);
    #1;
    check("rst_a_ready", a_ir, 0);
    check("rst_d_ready", d_ir, 0);
    check("rst_a_valid", a_ov, 0);
    check("rst_d_valid", d_ov, 0);
    @(negedge clk);
    rst_n = 1;
    #1;
    check("rel_a_ready", a_ir, 1);
    check("rel_d_ready", d_ir, 1);
    check("rel_a_valid", a_ov, 0);
    check("rel_d_valid", d_ov, 0);
    check("rel_a_payload", aout, 0);
    check("rel_d_payload", dout, 0);
    fin();

    for (int i = 0; i < 8; i++) begin
      a_iv = vt[i].av;
      a_or = vt[i].ar_o;
      ain  = vt[i].av ? mk_a(vt[i].ab) : '0;
      d_iv = vt[i].dv;
      d_or = vt[i].dr_o;
      din  = vt[i].dv ? mk_d(vt[i].db) : '0;
      #1;
      check($sformatf("v%0d_a_ready", i),
            a_ir, vt[i].e_ar);
      check($sformatf("v%0d_a_valid", i), a_ov,
            FLOW ? vt[i].e_avf : vt[i].e_av);
      check($sformatf("v%0d_d_ready", i),
            d_ir, vt[i].e_dr);
      check($sformatf("v%0d_d_valid", i), d_ov,
            FLOW ? vt[i].e_dvf : vt[i].e_dv);
      fin();
    end
    check("tbl_a_outs", a_outs, 3);
    check("tbl_d_outs", d_outs, 1);
    idle();

    sb.opcode  = 3'd4;
    sb.size    = 4'd3;
    sb.address = 32'h6000_0000;
    sb.mask    = 8'hFF;
    sb.data    = 64'h1234;
    a_iv = 1; a_or = 1; ain = sb;
    #1;
    check("single_c0_valid", a_ov, FLOW);
    fin();
    a_iv = 0; ain = '0;
    #1;
    check("single_c1_valid", a_ov, !FLOW);
    check("single_c1_data", aout, sb);
    fin();
    #1;
    check("single_c2_valid", a_ov, 0);
    check("single_c2_hold", aout, sb);
    fin();
    idle();

    a_outs = 0; d_outs = 0;
    a_first = -1; d_first = -1;
    for (int k = 0; k < 16; k++) begin
      a_iv = 1; ain = mk_a(100 + k);
      d_iv = 1; din = mk_d(100 + k);
      a_or = 1; d_or = 1;
      #1;
      fin();
    end
    a_iv = 0; d_iv = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      fin();
    end
    check("strm_a_outs", a_outs, 16);
    check("strm_d_outs", d_outs, 16);
    check("strm_a_span", a_last - a_first, 15);
    check("strm_d_span", d_last - d_first, 15);
    check("strm_qa_empty", qa.size(), 0);
    check("strm_qd_empty", qd.size(), 0);
    idle();

    for (int k = 0; k < 2; k++) begin
      rd = mk_d(200 + k);
      rd.denied  = 1'b1;
      rd.corrupt = 1'b1;
      d_iv = 1; din = rd;
      #1;
      fin();
    end
    d_iv = 0; din = '0;
    #1;
    check("pre_rst_d_valid", d_ov, 1);
    check("pre_rst_qd", qd.size(), 2);
    #2;
    rst_n = 0;
    #1;
    check("mid_rst_d_valid", d_ov, 0);
    check("mid_rst_a_ready", a_ir, 0);
    check("mid_rst_d_ready", d_ir, 0);
    check("mid_rst_d_payload", dout, 0);
    qd.delete();
    @(negedge clk);
    rst_n = 1;
    d_or = 1;
    n = d_outs;
    #1;
    check("post_rst_d_valid", d_ov, 0);
    check("post_rst_d_ready", d_ir, 1);
    fin();
    #1;
    check("post_rst_no_stale", d_ov, 0);
    fin();
    d_iv = 1; din = mk_d(7);
    #1;
    fin();
    d_iv = 0; din = '0;
    #1;
    fin();
    #1;
    fin();
    check("post_rst_d_outs", d_outs - n, 1);
    check("post_rst_qd_empty", qd.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
